// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump redirect, misaligned-target trap and RUN/HALT debug FSM
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h0000_0100),
  parameter int IALIGN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_branch_en,
  input  logic [XLEN-1:0] i_branch_off,
  input  logic            i_jump_en,
  input  logic [XLEN-1:0] i_jump_tgt,
  input  logic            i_ebreak,
  input  logic            i_resume,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_next_seq,
  output logic            o_halted,
  output logic            o_trap,
  output logic [XLEN-1:0] o_epc
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, seq, tgt;
  logic trap_q, trap_d, redirect, mis;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      pc_q <= RESET_VEC;
      epc_q <= '0;
      trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      epc_q <= epc_d;
      trap_q <= trap_d;
    end
  end
  always_comb begin
    state_d = (state_q == HALT) ? (i_resume ? RUN : HALT) : ((!i_stall && i_ebreak) ? HALT : RUN);
  end
  always_comb begin
    seq = pc_q + XLEN'(4);
    tgt = i_jump_en ? {i_jump_tgt[XLEN-1:1], 1'b0} : pc_q + i_branch_off;
    redirect = (state_q == RUN) && !i_stall && !i_ebreak && (i_jump_en || i_branch_en);
    mis = redirect && (IALIGN == 32) && tgt[1];
    pc_d = (state_q == HALT) ? (i_resume ? seq : pc_q) :
           (i_stall || i_ebreak) ? pc_q : mis ? TRAP_VEC : redirect ? tgt : seq;
    epc_d = mis ? pc_q : epc_q;
    trap_d = mis;
  end
  always_comb begin
    o_pc = pc_q;
    o_pc_next_seq = seq;
    o_halted = (state_q == HALT);
    o_trap = trap_q;
    o_epc = epc_q;
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: random and directed checks of pc_unit (IALIGN 32 and 16) against a behavioural model
module tb_pc_unit;
  logic clk = 1'b0;
  logic rst, stall, br, jmp, eb, rs;
  logic [31:0] off, tgt;
  logic [31:0] pc32, ns32, epc32, pc16, ns16, epc16;
  logic hlt32, trp32, hlt16, trp16;
  int n_checks = 0, n_errors = 0;
  logic [31:0] m_pc[2], m_epc[2];
  logic m_halt[2], m_trap[2];
  int ial[2] = '{32, 16};
  always #5 clk = ~clk;
  pc_unit #(.IALIGN(32)) u32 (.i_clk(clk), .i_rst(rst), .i_stall(stall), .i_branch_en(br), .i_branch_off(off),
    .i_jump_en(jmp), .i_jump_tgt(tgt), .i_ebreak(eb), .i_resume(rs), .o_pc(pc32), .o_pc_next_seq(ns32),
    .o_halted(hlt32), .o_trap(trp32), .o_epc(epc32));
  pc_unit #(.IALIGN(16)) u16 (.i_clk(clk), .i_rst(rst), .i_stall(stall), .i_branch_en(br), .i_branch_off(off),
    .i_jump_en(jmp), .i_jump_tgt(tgt), .i_ebreak(eb), .i_resume(rs), .o_pc(pc16), .o_pc_next_seq(ns16),
    .o_halted(hlt16), .o_trap(trp16), .o_epc(epc16));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] t;
      if (rst) begin
        m_pc[i] = 32'h0; m_epc[i] = 32'h0; m_halt[i] = 1'b0; m_trap[i] = 1'b0;
      end else if (m_halt[i]) begin
        m_trap[i] = 1'b0;
        if (rs) begin m_pc[i] = m_pc[i] + 32'd4; m_halt[i] = 1'b0; end
      end else begin
        m_trap[i] = 1'b0;
        if (stall) ;
        else if (eb) m_halt[i] = 1'b1;
        else if (jmp || br) begin
          t = jmp ? (tgt & ~32'd1) : m_pc[i] + off;
          if (ial[i] == 32 && (t % 4) >= 2) begin
            m_epc[i] = m_pc[i]; m_pc[i] = 32'h100; m_trap[i] = 1'b1;
          end else m_pc[i] = t;
        end else m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endtask
  task automatic compare_all();
    check("pc32", pc32, m_pc[0]);
    check("nseq32", ns32, m_pc[0] + 32'd4);
    check("halt32", {31'b0, hlt32}, {31'b0, m_halt[0]});
    check("trap32", {31'b0, trp32}, {31'b0, m_trap[0]});
    check("epc32", epc32, m_epc[0]);
    check("pc16", pc16, m_pc[1]);
    check("nseq16", ns16, m_pc[1] + 32'd4);
    check("halt16", {31'b0, hlt16}, {31'b0, m_halt[1]});
    check("trap16", {31'b0, trp16}, {31'b0, m_trap[1]});
    check("epc16", epc16, m_epc[1]);
    check("trap_in_halt", {31'b0, trp32 & hlt32}, 32'h0);
  endtask
  task automatic step(input logic r, s, b, input logic [31:0] o, input logic j, input logic [31:0] t,
                      input logic e, input logic re);
    rst = r; stall = s; br = b; off = o; jmp = j; tgt = t; eb = e; rs = re;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic jump(input logic [31:0] t);
    step(0, 0, 0, 0, 1, t, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin m_pc[i] = 0; m_epc[i] = 0; m_halt[i] = 0; m_trap[i] = 0; end
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_pc", pc32, 32'h0);
    check("rst_epc", epc32, 32'h0);
    idle(); check("seq1", pc32, 32'h4);
    idle(); check("seq2", pc32, 32'h8);
    idle(); check("seq3", pc32, 32'hC);
    check("seq3_next", ns32, 32'h10);
    jump(32'h20);
    step(0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0, 0); check("branch_back", pc32, 32'h18);
    jump(32'h20);
    step(0, 0, 1, 32'hFFFF_FFF8, 1, 32'h81, 0, 0); check("jump_wins", pc32, 32'h80);
    jump(32'h40);
    jump(32'h206);
    check("mis_pc32", pc32, 32'h100);
    check("mis_epc32", epc32, 32'h40);
    check("mis_trap32", {31'b0, trp32}, 32'h1);
    check("mis_pc16", pc16, 32'h206);
    check("mis_trap16", {31'b0, trp16}, 32'h0);
    idle(); check("trap_pulse_end", {31'b0, trp32}, 32'h0);
    jump(32'h50);
    step(0, 1, 0, 0, 0, 0, 1, 0); check("stall_beats_ebreak", {31'b0, hlt32}, 32'h0);
    check("stall_hold", pc32, 32'h50);
    step(0, 0, 0, 0, 0, 0, 1, 0); check("halted", {31'b0, hlt32}, 32'h1);
    for (int k = 0; k < 5; k++) begin
      step(0, k[0], 1, 32'h40, k[1], 32'h300, 1, 0);
      check("halt_hold", pc32, 32'h50);
      check("halt_flag", {31'b0, hlt32}, 32'h1);
    end
    step(0, 0, 0, 0, 0, 0, 0, 1); check("resume_pc", pc32, 32'h54);
    check("resume_flag", {31'b0, hlt32}, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 1); check("resume_in_run", pc32, 32'h58);
    jump(32'hFFFF_FFFC);
    idle(); check("wrap", pc32, 32'h0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1); check("rst_in_halt_pc", pc32, 32'h0);
    check("rst_in_halt_flag", {31'b0, hlt32}, 32'h0);
    jump(32'h2);
    step(1, 0, 0, 0, 0, 0, 0, 0); check("rst_trap_cycle", {31'b0, trp32}, 32'h0);
    for (int k = 0; k < 3000; k++)
      step($urandom_range(63) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0,
           ($urandom_range(1) == 0) ? $urandom : 32'($signed($urandom_range(64)) - 32),
           $urandom_range(4) == 0, $urandom, $urandom_range(15) == 0, $urandom_range(2) == 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the PC value after reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning the PC loaded on a misaligned-target trap.
REQ-004 SHALL have parameter IALIGN, default 32, legal values 16 or 32, meaning the instruction alignment in bits. The sequential step is 4 bytes.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port i_stall, input, 1 bit: freeze the PC this cycle.
REQ-008 SHALL have port i_branch_en, input, 1 bit: taken conditional branch.
REQ-009 SHALL have port i_branch_off, input, XLEN bits: signed PC-relative branch offset.
REQ-010 SHALL have port i_jump_en, input, 1 bit: absolute (register-indirect) jump.
REQ-011 SHALL have port i_jump_tgt, input, XLEN bits: absolute jump target.
REQ-012 SHALL have port i_ebreak, input, 1 bit: halt request.
REQ-013 SHALL have port i_resume, input, 1 bit: leave HALT.
REQ-014 SHALL have port o_pc, output, XLEN bits: current PC.
REQ-015 SHALL have port o_pc_next_seq, output, XLEN bits: o_pc+4 (combinational, for link writeback).
REQ-016 SHALL have port o_halted, output, 1 bit: FSM in HALT.
REQ-017 SHALL have port o_trap, output, 1 bit: one-cycle pulse on a misaligned-target trap.
REQ-018 SHALL have port o_epc, output, XLEN bits: PC of the instruction that caused the last trap.

Function
REQ-019 SHALL implement a two-state FSM, RUN and HALT; reset enters RUN.
REQ-020 In RUN, SHALL apply exactly one action per cycle, highest priority first: i_stall (hold) > i_ebreak (hold PC, go HALT) > i_jump_en > i_branch_en > sequential (o_pc+4).
REQ-021 Jump target SHALL be i_jump_tgt with bit 0 cleared.
REQ-022 Branch target SHALL be o_pc + i_branch_off, computed modulo 2^XLEN.
REQ-023 Sequential increment SHALL wrap modulo 2^XLEN (all-ones minus 3 -> 0).
REQ-024 A jump or branch target is misaligned when bit 1 is set and IALIGN=32; it is never misaligned when IALIGN=16.
REQ-025 On a misaligned target, SHALL in the same edge: load o_pc with TRAP_VEC, load o_epc with the old o_pc, and assert o_trap for exactly the following cycle.
REQ-026 Simultaneous i_jump_en and i_branch_en: the jump SHALL win and the branch SHALL be ignored.
REQ-027 In HALT, SHALL hold o_pc and ignore i_stall, i_jump_en, i_branch_en and i_ebreak.
REQ-028 In HALT with i_resume=1, SHALL go to RUN and load o_pc with o_pc+4 (step past the ebreak).
REQ-029 i_resume in RUN SHALL have no effect.
REQ-030 o_halted SHALL be 1 in the cycle after the edge entering HALT, and 0 in the cycle after the edge leaving it.
REQ-031 i_ebreak with i_stall=1 SHALL NOT halt; the stall wins.
REQ-032 o_trap SHALL never be asserted while in HALT.

Reset
REQ-033 i_rst=1 at a rising edge SHALL override all other inputs in any state, including mid-HALT and the trap cycle.
REQ-034 Reset SHALL give: o_pc=RESET_VEC, state RUN, o_halted=0, o_trap=0, o_epc=0.
REQ-035 No output SHALL be X after the first reset edge.

Verification
REQ-036 Reset then 3 idle cycles -> o_pc sequence 0x0, 0x4, 0x8, 0xC; o_pc_next_seq=0x10 in the last cycle.
REQ-037 o_pc=0x20, i_branch_en=1, i_branch_off=0xFFFF_FFF8 -> next o_pc=0x18; simultaneously set i_jump_en=1, i_jump_tgt=0x81 -> next o_pc=0x80.
REQ-038 o_pc=0x40, i_jump_en=1, i_jump_tgt=0x0000_0206 (IALIGN=32) -> next o_pc=0x100, o_epc=0x40, o_trap high for exactly one cycle; repeat with IALIGN=16 -> o_pc=0x206 and no trap.
REQ-039 o_pc=0x50: i_ebreak with i_stall=1 -> no halt; i_ebreak alone -> o_halted=1 and o_pc=0x50 for 5 cycles despite branch/jump pulses; i_resume -> o_pc=0x54, o_halted=0.
REQ-040 o_pc=0xFFFF_FFFC, idle -> o_pc=0x0; then i_rst asserted during HALT -> o_pc=RESET_VEC, o_halted=0.
